ssd_mux: RTL and testbench
==========================

SSD_MUX -- requirements
Module: ssd_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is displayed (legal >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and an are active-low, 0 means active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in, input, 4*DIGITS bits: hex nibbles; digit k is in[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port load, input, 1 bit: a capture strobe; in and blank are latched when it is high.
REQ-008 SHALL have port blank, input, DIGITS bits: per-digit blank request, latched with load.
REQ-009 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, with a at bit 0.
REQ-010 SHALL have port an, output, DIGITS bits: one-hot digit enable.

Function
REQ-011 SHALL hold a shadow register of 4*DIGITS value bits plus DIGITS blank bits, written only when load=1 at a clock edge.
REQ-012 SHALL keep a refresh counter that counts 0..REFRESH_DIV-1 and wraps to 0.
REQ-013 SHALL keep a digit index that counts 0..DIGITS-1, wraps to 0, and advances only on the cycle the refresh counter wraps.
REQ-014 SHALL decode seg combinationally from the registered index and the shadow register, so shadow writes are visible from the cycle after the load edge.
REQ-015 SHALL use active-high hex glyphs 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; seg is the glyph inverted when ACTIVE_LOW=1.
REQ-016 SHALL drive an to the one-hot value (1<<index), inverted when ACTIVE_LOW=1.
REQ-017 SHALL, for a blanked digit, turn all segments off (seg=7F when ACTIVE_LOW=1) while still driving that digit's an.
REQ-018 SHALL, when load and a refresh wrap happen in the same cycle, apply both: the new index displays the new shadow data.
REQ-019 SHALL, when DIGITS=1, hold the index at 0 and an constant, while the refresh counter still runs.
REQ-020 SHALL have no other state machine; the design is fixed-rate round-robin scanning with no handshake back-pressure.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear the refresh counter, the index, the shadow values and the blank bits to 0.
REQ-022 SHALL, after reset, output seg=40 and an=~1, i.e. DIGITS=4, ACTIVE_LOW=1 gives an=1110.
REQ-023 SHALL give rst priority over load when both are asserted.

Configuration
REQ-024 SHALL implement leading-zero suppression when macro SSD_MUX_LEADING_ZERO_BLANK_EN is defined: each digit above 0 whose value and all higher digits' values are 0 is treated as blanked, and digit 0 is never suppressed.
REQ-025 SHALL, without SSD_MUX_LEADING_ZERO_BLANK_EN, blank digits only through the latched blank bits.

Structure
REQ-026 SHALL place the 16-entry glyph constant table and the SEG_OFF constant in shared package ssd_pkg.
REQ-027 SHALL implement nibble-to-glyph decoding in one sub-module, ssd_glyph: 4-bit input, 7-bit active-high output.
REQ-028 SHALL apply polarity inversion and blanking in ssd_mux, not in ssd_glyph.

Verification (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless noted)
REQ-029 SHALL cover reset: hold rst for 2 cycles -> seg=40, an=1110, and the first an change after exactly 4 cycles.
REQ-030 SHALL cover a full scan: load in=0x4321, blank=0 -> an sequence 1110,1101,1011,0111,1110, each held 4 cycles, with seg=79,24,30,19.
REQ-031 SHALL cover blanking: load in=0xABCD, blank=0100 -> seg=7F while an=1011, and the other digits decode normally.
REQ-032 SHALL cover load at a wrap: assert load with in=0x000F on the cycle the counter wraps -> the next digit shows the new data in that same displayed slot.
REQ-033 SHALL cover leading-zero suppression with the macro defined: load in=0x0050 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40; without the macro, digits 3 and 2 show 40.
REQ-034 SHALL cover mid-scan reset plus ACTIVE_LOW=0: rst asserted while index=2 -> an=0001 and seg=3F on the next cycle.

Source files
------------

// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_pkg
// Brief    : Shared seven-segment constants: hex glyph table and blank pattern
// Revision : 1.0
// ============================================================================
package ssd_pkg;

   // Active-high glyphs {g,f,e,d,c,b,a}; entry 15 is leftmost
   localparam logic [15:0][6:0] c_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic logic [6:0] glyph_of(input logic [3:0] nib);
      return c_GLYPH[nib];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_glyph.sv
`default_nettype none
// ============================================================================
// Module   : ssd_glyph
// Brief    : Hex nibble to active-high seven-segment glyph
// Revision : 1.0
// ============================================================================
module ssd_glyph
   import ssd_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_glyph
);

   assign o_glyph = glyph_of(i_nib);

endmodule
`default_nettype wire

// File: rtl/ssd_mux.sv
`default_nettype none
// ============================================================================
// Module   : ssd_mux
// Brief    : Round-robin multiplexed seven-segment driver with load-strobed
//            shadow register. Define SSD_MUX_LEADING_ZERO_BLANK_EN to blank
//            leading zero digits (digit 0 always shown).
// Revision : 1.0
// ============================================================================
module ssd_mux
   import ssd_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter bit ACTIVE_LOW  = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   in,
   input  logic                  load,
   input  logic [DIGITS-1:0]     blank,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CNT_W-1:0]    r_cnt;
   logic [IDX_W-1:0]    r_idx;
   logic [4*DIGITS-1:0] r_val;
   logic [DIGITS-1:0]   r_blank;

   logic                w_wrap;
   logic [DIGITS-1:0]   w_blank_eff;
   logic [3:0]          w_nib;
   logic                w_blank_sel;
   logic [DIGITS-1:0]   w_an_hi;
   logic [6:0]          w_glyph;
   logic [6:0]          w_seg_hi;

   assign w_wrap = (r_cnt == CNT_W'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)         r_cnt <= '0;
      else if (w_wrap) r_cnt <= '0;
      else             r_cnt <= r_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_val   <= '0;
         r_blank <= '0;
      end else if (load) begin
         r_val   <= in;
         r_blank <= blank;
      end
   end

   generate
      if (DIGITS > 1) begin : g_idx_scan
         always_ff @(posedge clk) begin
            if (rst)
               r_idx <= '0;
            else if (w_wrap)
               r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
         end
      end else begin : g_idx_fixed
         assign r_idx = '0;
      end
   endgenerate

`ifdef SSD_MUX_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] w_lz;

   // Scan from the top digit down; a digit is a leading zero while every digit
   // at or above it is zero. Digit 0 is never considered.
   always_comb begin : p_lz
      logic l_zero;
      l_zero = 1'b1;
      w_lz   = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         l_zero  = l_zero & (r_val[4*k +: 4] == 4'h0);
         w_lz[k] = l_zero;
      end
   end

   assign w_blank_eff = r_blank | w_lz;
`else
   assign w_blank_eff = r_blank;
`endif

   always_comb begin
      w_nib       = 4'h0;
      w_blank_sel = 1'b0;
      w_an_hi     = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib       = r_val[4*k +: 4];
            w_blank_sel = w_blank_eff[k];
            w_an_hi[k]  = 1'b1;
         end
      end
   end

   ssd_glyph u_glyph (
      .i_nib   (w_nib),
      .o_glyph (w_glyph)
   );

   assign w_seg_hi = w_blank_sel ? SEG_OFF : w_glyph;

   generate
      if (ACTIVE_LOW) begin : g_pol_low
         assign seg = ~w_seg_hi;
         assign an  = ~w_an_hi;
      end else begin : g_pol_high
         assign seg = w_seg_hi;
         assign an  = w_an_hi;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ssd_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_mux
// Brief    : Directed self-checking bench for ssd_mux; expectations follow
//            SSD_MUX_LEADING_ZERO_BLANK_EN when it is defined.
// Revision : 1.0
// ============================================================================
module tb_ssd_mux;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: DIGITS=4, REFRESH_DIV=4, active-low
   logic        rst = 1'b1, load = 1'b0;
   logic [15:0] din = '0;
   logic [3:0]  blk = '0;
   logic [6:0]  seg;
   logic [3:0]  an;

   // Active-high DUT for mid-scan reset
   logic        rst2 = 1'b1, load2 = 1'b0;
   logic [15:0] din2 = '0;
   logic [3:0]  blk2 = '0;
   logic [6:0]  seg2;
   logic [3:0]  an2;

   // Single-digit DUT
   logic        rst3 = 1'b1, load3 = 1'b0;
   logic [3:0]  din3 = '0;
   logic [0:0]  blk3 = '0;
   logic [6:0]  seg3;
   logic [0:0]  an3;

   ssd_mux #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .in(din), .load(load), .blank(blk), .seg(seg), .an(an));

   ssd_mux #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut2 (
      .clk(clk), .rst(rst2), .in(din2), .load(load2), .blank(blk2), .seg(seg2), .an(an2));

   ssd_mux #(.DIGITS(1), .REFRESH_DIV(2), .ACTIVE_LOW(1'b1)) dut3 (
      .clk(clk), .rst(rst3), .in(din3), .load(load3), .blank(blk3), .seg(seg3), .an(an3));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0]     din;
      logic [3:0]      blk;
      logic [3:0][6:0] seg_exp;   // {digit3, digit2, digit1, digit0}
   } vec_t;

   vec_t vecs [6];

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset1();
      rst = 1'b1; load = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] an_exp;
      logic [6:0] lz_seg;
`ifdef SSD_MUX_LEADING_ZERO_BLANK_EN
      lz_seg = 7'h7F;
`else
      lz_seg = 7'h40;
`endif
      vecs[0] = '{16'h4321, 4'b0000, {7'h19, 7'h30, 7'h24, 7'h79}};
      vecs[1] = '{16'hABCD, 4'b0100, {7'h08, 7'h7F, 7'h46, 7'h21}};
      vecs[2] = '{16'h0050, 4'b0000, {lz_seg, lz_seg, 7'h12, 7'h40}};
      vecs[3] = '{16'h89EF, 4'b1001, {7'h7F, 7'h10, 7'h06, 7'h7F}};
      vecs[4] = '{16'h0000, 4'b0000, {lz_seg, lz_seg, lz_seg, 7'h40}};
      vecs[5] = '{16'h1007, 4'b0000, {7'h79, 7'h40, 7'h40, 7'h78}};

      // Reset state and first digit change after exactly REFRESH_DIV cycles
      tick(2);
      rst = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      chk("reset seg", seg, 7'h40);
      chk("reset an", an, 4'b1110);
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         chk("first scan an", an, (i < 4) ? 4'b1110 : 4'b1101);
      end

      // Table-driven full scans
      for (int v = 0; v < 6; v++) begin
         reset1();
         din = vecs[v].din; blk = vecs[v].blk; load = 1'b1;
         tick(1);
         load = 1'b0;
         for (int d = 0; d <= 4; d++) begin
            an_exp = ~(4'b0001 << (d % 4));
            chk($sformatf("vec%0d d%0d an", v, d % 4), an, an_exp);
            chk($sformatf("vec%0d d%0d seg", v, d % 4), seg, vecs[v].seg_exp[d % 4]);
            tick((d == 0) ? 3 : 4);
         end
      end

      // Load coinciding with a refresh wrap
      reset1();
      din = 16'h4321; blk = 4'b0000; load = 1'b1;
      tick(1);
      load = 1'b0;
      tick(2);
      chk("wrap pre seg", seg, 7'h79);
      chk("wrap pre an", an, 4'b1110);
      din = 16'h000F; load = 1'b1;
      tick(1);
      load = 1'b0;
      chk("wrap an", an, 4'b1101);
      chk("wrap seg", seg, lz_seg);
      tick(12);
      chk("wrap d0 an", an, 4'b1110);
      chk("wrap d0 seg", seg, 7'h0E);

      // Reset has priority over load
      rst = 1'b1; load = 1'b1; din = 16'hFFFF; blk = 4'b0000;
      tick(1);
      rst = 1'b0; load = 1'b0;
      chk("rst prio seg", seg, 7'h40);
      chk("rst prio an", an, 4'b1110);
      tick(1);
      chk("rst prio hold seg", seg, 7'h40);

      // Mid-scan reset on the active-high instance
      rst2 = 1'b1;
      tick(2);
      rst2 = 1'b0;
      din2 = 16'h4321; load2 = 1'b1;
      tick(1);
      load2 = 1'b0;
      tick(7);
      chk("al0 idx2 an", an2, 4'b0100);
      chk("al0 idx2 seg", seg2, 7'h4F);
      rst2 = 1'b1;
      tick(1);
      rst2 = 1'b0;
      chk("al0 rst an", an2, 4'b0001);
      chk("al0 rst seg", seg2, 7'h3F);

      // Single digit: index fixed, an constant
      din3 = 4'h5; load3 = 1'b1;
      tick(1);
      load3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("d1 an", an3, 1'b0);
         chk("d1 seg", seg3, 7'h12);
         tick(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
